// File: rtl/mire_pkg.sv
// Shared types and constants for the test-pattern (mire) generator.
// Holds the FSM states, grid geometry and pixel colour helper.
package mire_pkg;

    localparam int         GRID_W  = 5;
    localparam logic [7:0] BG_BLUE = 8'h80;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_e;

    function automatic int cw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [23:0] mire_rgb(
        input logic [7:0] x8,
        input logic [7:0] y8
    );
        logic grid;
        grid = (x8[GRID_W-1:0] == '0) || (y8[GRID_W-1:0] == '0);
        return grid ? 24'hFFFFFF : {x8, y8, BG_BLUE};
    endfunction

endpackage

// File: rtl/mire_if.sv
// Wishbone bus bundle between the generator and the memory side.
// The generator is the master; the memory controller is the slave.
interface mire_if;

    logic        wshb_cyc;
    logic        wshb_stb;
    logic        wshb_we;
    logic [31:0] wshb_adr;
    logic [31:0] wshb_dat_ms;
    logic [3:0]  wshb_sel;
    logic [2:0]  wshb_cti;
    logic [1:0]  wshb_bte;
    logic        wshb_ack;
    logic [31:0] wshb_dat_sm;

    modport master (
        output wshb_cyc, wshb_stb, wshb_we, wshb_adr,
        output wshb_dat_ms, wshb_sel, wshb_cti, wshb_bte,
        input  wshb_ack, wshb_dat_sm
    );

    modport slave (
        input  wshb_cyc, wshb_stb, wshb_we, wshb_adr,
        input  wshb_dat_ms, wshb_sel, wshb_cti, wshb_bte,
        output wshb_ack, wshb_dat_sm
    );

endinterface

// File: rtl/mire_xy_cnt.sv
// Raster counter: x within y, plus a linear pixel index.
// The index is kept incrementally so no multiplier is needed.
module mire_xy_cnt
    import mire_pkg::*;
#(
    parameter int HDISP = 800,
    parameter int VDISP = 480
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en_i,
    input  logic                          clr_i,
    output logic [cw(HDISP)-1:0]          x_o,
    output logic [cw(VDISP)-1:0]          y_o,
    output logic [cw(HDISP*VDISP)-1:0]    pix_o,
    output logic                          last_o
);

    localparam int XW = cw(HDISP);
    localparam int YW = cw(VDISP);
    localparam int PW = cw(HDISP*VDISP);

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [PW-1:0] p_q, p_d;

    assign last_o = (p_q == PW'(HDISP*VDISP-1));

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        p_d = p_q;
        if (clr_i || (en_i && last_o)) begin
            x_d = '0;
            y_d = '0;
            p_d = '0;
        end else if (en_i) begin
            p_d = p_q + 1'b1;
            if (x_q == XW'(HDISP-1)) begin
                x_d = '0;
                y_d = y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= '0;
            y_q <= '0;
            p_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
            p_q <= p_d;
        end
    end

    assign x_o   = x_q;
    assign y_o   = y_q;
    assign pix_o = p_q;

endmodule

// File: rtl/mire_gen.sv
// Writes a grid test pattern into a framebuffer over Wishbone,
// releasing the bus for one cycle after every burst of acks.
module mire_gen
    import mire_pkg::*;
#(
    parameter int HDISP      = 800,
    parameter int VDISP      = 480,
    parameter int BURST_LEN  = 64,
    parameter int CONTINUOUS = 0
) (
    input  logic   wshb_clk,
    input  logic   wshb_rst_n,
    input  logic   start,
    output logic   busy,
    output logic   frame_done,
    mire_if.master wb
);

    localparam int XW = cw(HDISP);
    localparam int YW = cw(VDISP);
    localparam int PW = cw(HDISP*VDISP);
    localparam int BW = cw(BURST_LEN);

    state_e        state_q, state_d;
    logic [BW-1:0] burst_q, burst_d;
    logic          done_q, done_d;
    logic          inc, clr, last;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [PW-1:0] pix;
    logic          unused_ok;

    mire_xy_cnt #(
        .HDISP (HDISP),
        .VDISP (VDISP)
    ) u_cnt (
        .clk    (wshb_clk),
        .rst_n  (wshb_rst_n),
        .en_i   (inc),
        .clr_i  (clr),
        .x_o    (x),
        .y_o    (y),
        .pix_o  (pix),
        .last_o (last)
    );

    always_comb begin
        state_d = state_q;
        burst_d = burst_q;
        done_d  = 1'b0;
        inc     = 1'b0;
        clr     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = WRITE;
                    burst_d = '0;
                    clr     = 1'b1;
                end
            end
            WRITE: begin
                if (wb.wshb_ack) begin
                    inc = 1'b1;
                    // End of frame takes precedence over end of burst
                    if (last) begin
                        done_d  = 1'b1;
                        burst_d = '0;
                        state_d = (CONTINUOUS != 0) ? PAUSE : DONE;
                    end else if (burst_q == BW'(BURST_LEN-1)) begin
                        burst_d = '0;
                        state_d = PAUSE;
                    end else begin
                        burst_d = burst_q + 1'b1;
                    end
                end
            end
            PAUSE: begin
                burst_d = '0;
                state_d = WRITE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge wshb_clk or negedge wshb_rst_n) begin
        if (!wshb_rst_n) begin
            state_q <= IDLE;
            burst_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            burst_q <= burst_d;
            done_q  <= done_d;
        end
    end

    assign busy       = (state_q == WRITE) || (state_q == PAUSE);
    assign frame_done = done_q;

    assign wb.wshb_cyc    = (state_q == WRITE);
    assign wb.wshb_stb    = (state_q == WRITE);
    assign wb.wshb_we     = 1'b1;
    assign wb.wshb_sel    = 4'hF;
    assign wb.wshb_cti    = 3'b000;
    assign wb.wshb_bte    = 2'b00;
    assign wb.wshb_adr    = 32'({pix, 2'b00});
    assign wb.wshb_dat_ms = {8'h00, mire_rgb(8'(x), 8'(y))};

    assign unused_ok = ^{wb.wshb_dat_sm, x, y};

endmodule
